regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised integer register bank for the pipelined core, with N read ports, write-through bypass, a per-register busy scoreboard for hazard detection, and a hardware clear sweep after reset. It sits between decode (read/issue) and write-back. It replaces the fixed 2-read, 64-bit bank. Register 0 stays hardwired to zero.

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, register count; power of two, ≥2
- NRD, 2, number of read ports
- AW, $clog2(NREGS), address width (derived, not overridden)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- rs_addr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rs_data  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]
- rs_busy  out  NRD  port k source has a pending producer
- rd_addr  in  AW  write-back address
- rd_data  in  XLEN  write-back data
- reg_write  in  1  write-back strobe
- issue_valid  in  1  instruction with destination issued this cycle
- issue_rd  in  AW  destination being marked busy
- flush  in  1  clear all busy bits (pipeline flush)
- ready  out  1  clear sweep done; bank usable

## Operation
- States are CLEAR and RUN.
- While rst=0:
  - state is CLEAR, sweep counter cnt=0, all busy bits 0, ready=0.
  - No register writes happen.
- CLEAR:
  - Each cycle writes 0 to registers[cnt], then cnt increments.
  - The cycle with cnt=NREGS-1 moves the state to RUN.
  - reg_write, issue_valid and flush are ignored.
  - rs_data reads 0 and rs_busy reads 0.
- RUN, write path:
  - When reg_write=1 and rd_addr≠0, registers[rd_addr] ← rd_data and busy[rd_addr] ← 0.
- RUN, issue path:
  - When issue_valid=1 and issue_rd≠0, busy[issue_rd] ← 1.
- Priority for the busy bit of one register in one cycle: flush clear < write-back clear < issue set.
  - An issue to a register wins over a write-back to the same register in the same cycle (a new producer replaces the old).
  - An issue in a flush cycle survives the flush.
- Read port k, combinational:
  - If rs_addr_k=0: data 0, busy 0.
  - Else if reg_write=1 and rd_addr=rs_addr_k: data is rd_data and busy is 0 (bypass).
  - Otherwise: data is registers[rs_addr_k] and busy is busy[rs_addr_k].
- Register 0 is never written and never marked busy. Writes and issues to register 0 are silently dropped.
- rst=0 in the middle of RUN or CLEAR restarts the sweep from cnt=0. Register contents are not guaranteed until ready=1.

## Timing
- Reset values: ready=0, rs_busy=0, rs_data=0, state=CLEAR, cnt=0, busy bits all 0.
- ready is registered. It rises exactly NREGS rising edges after the first edge that samples rst=1 (32 edges at the default).
- Read latency: 0 cycles. A write-back is visible through the bypass in the same cycle and from the array on the next cycle.
- Busy set latency: 1 cycle. rs_busy reflects an issue from cycle t starting in cycle t+1.
- Flush takes effect on the next edge. rs_busy=0 for all registers from the next cycle, except an issue_rd issued in the same cycle.
- There is no backpressure. All inputs are single-cycle strobes.

## Structure
- Shared package regfile_pkg holds:
  - the state enum (CLEAR, RUN);
  - the default constants (XLEN_DEF=64, NREGS_DEF=32, NRD_DEF=2).
- Sub-module reg_scoreboard holds:
  - the NREGS-bit busy vector and its set/clear/flush priority logic;
  - inputs clk, rst, the write and issue strobes with their addresses, and flush;
  - output: the busy vector.
- The data array, sweep FSM and read muxes stay in the top module.

## Test plan
- Sweep: release rst, then poll ready. ready=0 for 32 cycles, then 1. Every read port returns 0 for registers 1..31.
- Write/bypass: in RUN, write 0xDEAD_BEEF to x5 with rs_addr0=5 in the same cycle. rs_data0=0xDEADBEEF, rs_busy0=0 in that cycle, and the next cycle still reads 0xDEADBEEF.
- x0: write 0x1234 to x0 and issue to x0. Reading x0 returns 0 with busy 0.
- Scoreboard:
  - Issue to x7. Next cycle rs_busy for x7 =1.
  - Write back x7 with 0x9 while issuing x7 in the same cycle. x7 stays busy and reads 0x9.
  - Write back x7 alone. Next cycle busy=0.
- Flush: mark x3, x4, x8 busy, then flush while issuing x9. Next cycle only x9 is busy.
- Mid-run reset:
  - Write x10=0x55, then hold rst=0 for 1 cycle.
  - ready drops, writes attempted during the sweep are dropped, and x10 reads 0 after ready returns 32 cycles later.
  - Repeat with NRD=4, XLEN=32, NREGS=16; ready rises after 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the register bank
//
// Purpose: state enum for the clear sweep and default bank dimensions.
// Ports:   none (package).
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits for hazard detection
//
// Purpose: holds one busy bit per register; issue sets, write-back clears,
//          flush clears everything. Register 0 is never marked busy.
// Ports:
//   clk, rst          clock, synchronous active-low reset (clears all bits)
//   reg_write/rd_addr write-back strobe and address (clears busy)
//   issue_valid/rd    issue strobe and destination (sets busy)
//   flush             clear all busy bits
//   busy              registered busy vector, one bit per register
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     flush,
  output logic [NREGS-1:0]         busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Later assignments win: flush < write-back clear < issue set, so a new
  // producer always survives both a same-cycle write-back and a flush.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end
    if (reg_write && (rd_addr != '0)) begin
      busy_d[rd_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register bank with bypass, scoreboard, clear sweep
//
// Purpose: NREGS x XLEN integer register bank with NRD combinational read
//          ports, write-through bypass, busy scoreboard and a post-reset
//          sweep that zeroes every register before ready rises.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   rs_addr/rs_data/busy   NRD packed read ports (port k at slice k)
//   rd_addr/rd_data        write-back address/data, reg_write strobe
//   issue_valid/issue_rd   destination being marked busy
//   flush                  clear all busy bits
//   ready                  sweep finished, bank usable
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NRD*$clog2(NREGS)-1:0] rs_addr,
  output logic [NRD*XLEN-1:0]          rs_data,
  output logic [NRD-1:0]               rs_busy,
  input  logic [$clog2(NREGS)-1:0]     rd_addr,
  input  logic [XLEN-1:0]              rd_data,
  input  logic                         reg_write,
  input  logic                         issue_valid,
  input  logic [$clog2(NREGS)-1:0]     issue_rd,
  input  logic                         flush,
  output logic                         ready
);

  localparam int AW = $clog2(NREGS);

  rf_state_e        state_q;
  logic [AW-1:0]    cnt_q;
  logic             ready_q;
  logic             run;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  assign run   = (state_q == RUN);
  assign ready = ready_q;

  // Sweep FSM: one register cleared per cycle; ready rises on the same edge
  // that leaves CLEAR, i.e. NREGS edges after reset is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + AW'(1);
      if (cnt_q == AW'(NREGS - 1)) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Data array has no reset of its own; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        regs_q[cnt_q] <= '0;
      end else if (reg_write && (rd_addr != '0)) begin
        regs_q[rd_addr] <= rd_data;
      end
    end
  end

  // Strobes are masked during the sweep so nothing can mark a register busy
  // before the bank is usable.
  reg_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write & run),
    .rd_addr    (rd_addr),
    .issue_valid(issue_valid & run),
    .issue_rd   (issue_rd),
    .flush      (flush & run),
    .busy       (busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    logic          byp;

    assign addr = rs_addr[k*AW +: AW];
    assign hit  = run && (addr != '0);
    // Same-cycle write-back forwards its data and hides the stale busy bit.
    assign byp  = reg_write && (rd_addr == addr);

    assign rs_data[k*XLEN +: XLEN] = !hit ? '0 : (byp ? rd_data : regs_q[addr]);
    assign rs_busy[k]              = hit && !byp && busy[addr];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int XL = 64, NR = 32, NP = 2, AW = 5;
  localparam int XL2 = 32, NR2 = 16, NP2 = 4, AW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic             rst;
  logic [NP*AW-1:0] rs_addr;
  logic [NP*XL-1:0] rs_data;
  logic [NP-1:0]    rs_busy;
  logic [AW-1:0]    rd_addr;
  logic [XL-1:0]    rd_data;
  logic             reg_write, issue_valid, flush, ready;
  logic [AW-1:0]    issue_rd;

  // small instance
  logic               rst2;
  logic [NP2*AW2-1:0] rs_addr2;
  logic [NP2*XL2-1:0] rs_data2;
  logic [NP2-1:0]     rs_busy2;
  logic [AW2-1:0]     rd_addr2;
  logic [XL2-1:0]     rd_data2;
  logic               reg_write2, issue_valid2, flush2, ready2;
  logic [AW2-1:0]     issue_rd2;

  regfile_scoreboard u_dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush), .ready(ready)
  );

  regfile_scoreboard #(.XLEN(XL2), .NREGS(NR2), .NRD(NP2)) u_dut2 (
    .clk(clk), .rst(rst2), .rs_addr(rs_addr2), .rs_data(rs_data2), .rs_busy(rs_busy2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .reg_write(reg_write2),
    .issue_valid(issue_valid2), .issue_rd(issue_rd2), .flush(flush2), .ready(ready2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural register values, busy set, sweep progress.
  logic [XL-1:0] m_mem [NR];
  bit [NR-1:0]   m_busy;
  bit            m_ready;
  int            m_sweep;

  task automatic model_edge();
    if (!rst) begin
      m_ready = 0;
      m_sweep = 0;
      m_busy  = '0;
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
    end else if (!m_ready) begin
      m_sweep++;
      if (m_sweep == NR) m_ready = 1;
    end else begin
      if (flush) m_busy = '0;
      if (reg_write && rd_addr != 0) begin
        m_mem[rd_addr]  = rd_data;
        m_busy[rd_addr] = 0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [AW-1:0] a;
    logic [XL-1:0] ed;
    bit            eb;
    chk({tag, ".ready"}, 64'(ready), 64'(m_ready));
    for (int k = 0; k < NP; k++) begin
      a = rs_addr[k*AW +: AW];
      if (!m_ready || a == 0) begin
        ed = '0; eb = 0;
      end else if (reg_write && rd_addr == a) begin
        ed = rd_data; eb = 0;
      end else begin
        ed = m_mem[a]; eb = m_busy[a];
      end
      chk($sformatf("%s.d%0d", tag, k), rs_data[k*XL +: XL], ed);
      chk($sformatf("%s.b%0d", tag, k), 64'(rs_busy[k]), 64'(eb));
    end
  endtask

  task automatic idle();
    reg_write = 0; rd_addr = '0; rd_data = '0;
    issue_valid = 0; issue_rd = '0; flush = 0;
  endtask

  task automatic idle2();
    reg_write2 = 0; rd_addr2 = '0; rd_data2 = '0;
    issue_valid2 = 0; issue_rd2 = '0; flush2 = 0; rs_addr2 = '0;
  endtask

  // Sweep on the default instance: ready low for NR edges, strobes ignored.
  task automatic sweep_main(input string tag, input logic [AW-1:0] probe);
    for (int i = 0; i <= NR; i++) begin
      if (i < NR) begin
        reg_write = 1; rd_addr = probe; rd_data = 64'h77;
        issue_valid = 1; issue_rd = probe; flush = 1;
        rs_addr = {AW'(i), probe};
      end else begin
        idle();
        rs_addr = '0;
      end
      #1;
      chk($sformatf("%s.ready%0d", tag, i), 64'(ready), 64'(i == NR));
      if (i < NR) begin
        chk($sformatf("%s.d%0d", tag, i), rs_data[XL-1:0], 64'h0);
        chk($sformatf("%s.b%0d", tag, i), 64'(rs_busy[0]), 64'h0);
        tick();
      end
    end
  endtask

  task automatic sweep_small(input string tag);
    for (int i = 0; i <= NR2; i++) begin
      #1;
      chk($sformatf("%s.ready%0d", tag, i), 64'(ready2), 64'(i == NR2));
      if (i < NR2) tick();
    end
  endtask

  typedef struct {
    int we; int wa; logic [63:0] wd;
    int iv; int ia; int fl;
    int a0; int a1;
    logic [63:0] d0; int b0;
    logic [63:0] d1; int b1;
  } vec_t;

  vec_t vt [16];

  initial begin
    vt[0]  = '{1, 5, 64'hDEAD_BEEF, 0, 0, 0, 5, 0, 64'hDEAD_BEEF, 0, 64'h0, 0};
    vt[1]  = '{0, 0, 64'h0, 0, 0, 0, 5, 5, 64'hDEAD_BEEF, 0, 64'hDEAD_BEEF, 0};
    vt[2]  = '{1, 0, 64'h1234, 1, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0};
    vt[3]  = '{0, 0, 64'h0, 0, 0, 0, 0, 5, 64'h0, 0, 64'hDEAD_BEEF, 0};
    vt[4]  = '{0, 0, 64'h0, 1, 7, 0, 7, 0, 64'h0, 0, 64'h0, 0};
    vt[5]  = '{0, 0, 64'h0, 0, 0, 0, 7, 7, 64'h0, 1, 64'h0, 1};
    vt[6]  = '{1, 7, 64'h9, 1, 7, 0, 7, 5, 64'h9, 0, 64'hDEAD_BEEF, 0};
    vt[7]  = '{0, 0, 64'h0, 0, 0, 0, 7, 0, 64'h9, 1, 64'h0, 0};
    vt[8]  = '{1, 7, 64'hA, 0, 0, 0, 7, 7, 64'hA, 0, 64'hA, 0};
    vt[9]  = '{0, 0, 64'h0, 0, 0, 0, 7, 0, 64'hA, 0, 64'h0, 0};
    vt[10] = '{0, 0, 64'h0, 1, 3, 0, 3, 4, 64'h0, 0, 64'h0, 0};
    vt[11] = '{0, 0, 64'h0, 1, 4, 0, 3, 4, 64'h0, 1, 64'h0, 0};
    vt[12] = '{0, 0, 64'h0, 1, 8, 0, 4, 8, 64'h0, 1, 64'h0, 0};
    vt[13] = '{0, 0, 64'h0, 1, 9, 1, 3, 8, 64'h0, 1, 64'h0, 1};
    vt[14] = '{0, 0, 64'h0, 0, 0, 0, 3, 9, 64'h0, 0, 64'h0, 1};
    vt[15] = '{0, 0, 64'h0, 0, 0, 0, 4, 8, 64'h0, 0, 64'h0, 0};

    rst = 0; rst2 = 0; rs_addr = '0;
    idle(); idle2();
    for (int i = 0; i < 3; i++) tick();

    // reset state
    chk("rst.ready", 64'(ready), 64'h0);
    chk("rst.busy", 64'(rs_busy), 64'h0);
    rs_addr = {AW'(9), AW'(1)};
    #1;
    chk("rst.data", rs_data[XL-1:0], 64'h0);
    chk("rst.ready2", 64'(ready2), 64'h0);

    // power-on sweep, then every register reads 0
    rst = 1;
    sweep_main("sweep", AW'(6));
    for (int a = 1; a < NR; a++) begin
      rs_addr = {AW'(NR - a), AW'(a)};
      #1;
      chk($sformatf("zero.d0.x%0d", a), rs_data[XL-1:0], 64'h0);
      chk($sformatf("zero.d1.x%0d", NR - a), rs_data[2*XL-1:XL], 64'h0);
      chk($sformatf("zero.b.x%0d", a), 64'(rs_busy), 64'h0);
    end

    // directed vectors
    for (int i = 0; i < 16; i++) begin
      reg_write   = (vt[i].we != 0);
      rd_addr     = AW'(vt[i].wa);
      rd_data     = vt[i].wd;
      issue_valid = (vt[i].iv != 0);
      issue_rd    = AW'(vt[i].ia);
      flush       = (vt[i].fl != 0);
      rs_addr     = {AW'(vt[i].a1), AW'(vt[i].a0)};
      #1;
      chk($sformatf("vec%0d.d0", i), rs_data[XL-1:0], vt[i].d0);
      chk($sformatf("vec%0d.b0", i), 64'(rs_busy[0]), 64'(vt[i].b0));
      chk($sformatf("vec%0d.d1", i), rs_data[2*XL-1:XL], vt[i].d1);
      chk($sformatf("vec%0d.b1", i), 64'(rs_busy[1]), 64'(vt[i].b1));
      tick();
    end
    idle();

    // mid-run reset: x10 is lost, writes during the sweep are dropped
    reg_write = 1; rd_addr = AW'(10); rd_data = 64'h55;
    tick();
    idle();
    rs_addr = {AW'(0), AW'(10)};
    #1;
    chk("mid.x10.before", rs_data[XL-1:0], 64'h55);
    rst = 0;
    tick();
    rst = 1;
    #1;
    chk("mid.ready.drop", 64'(ready), 64'h0);
    sweep_main("mid", AW'(10));
    rs_addr = {AW'(5), AW'(10)};
    #1;
    chk("mid.x10.after", rs_data[XL-1:0], 64'h0);
    chk("mid.x5.after", rs_data[2*XL-1:XL], 64'h0);
    chk("mid.busy.after", 64'(rs_busy), 64'h0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] a0, a1;
      rst = ($urandom_range(0, 149) != 0);
      a0 = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NR - 1));
      a1 = AW'($urandom_range(0, NR - 1));
      rs_addr     = {a1, a0};
      reg_write   = ($urandom_range(0, 1) == 1);
      rd_addr     = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, NR - 1));
      rd_data     = {$urandom, $urandom};
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd    = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, NR - 1));
      flush       = ($urandom_range(0, 19) == 0);
      #1;
      check_model($sformatf("rnd%0d", c));
      tick();
    end
    idle();
    rst = 1;

    // small instance: 4 ports, 32-bit, 16 registers
    rst2 = 1;
    sweep_small("s2.sweep");
    reg_write2 = 1; rd_addr2 = AW2'(3); rd_data2 = 32'hCAFE_0003;
    rs_addr2 = {AW2'(3), AW2'(3), AW2'(3), AW2'(3)};
    #1;
    for (int k = 0; k < NP2; k++) begin
      chk($sformatf("s2.byp.d%0d", k), 64'(rs_data2[k*XL2 +: XL2]), 64'hCAFE_0003);
      chk($sformatf("s2.byp.b%0d", k), 64'(rs_busy2[k]), 64'h0);
    end
    tick();
    reg_write2 = 1; rd_addr2 = AW2'(15); rd_data2 = 32'h0F0F_0F0F;
    issue_valid2 = 1; issue_rd2 = AW2'(3);
    tick();
    idle2();
    rs_addr2 = {AW2'(15), AW2'(0), AW2'(15), AW2'(3)};
    #1;
    chk("s2.x3.d", 64'(rs_data2[XL2-1:0]), 64'hCAFE_0003);
    chk("s2.x3.b", 64'(rs_busy2[0]), 64'h1);
    chk("s2.x15.d", 64'(rs_data2[2*XL2-1:XL2]), 64'h0F0F_0F0F);
    chk("s2.x0.d", 64'(rs_data2[3*XL2-1:2*XL2]), 64'h0);
    chk("s2.x15.d3", 64'(rs_data2[4*XL2-1:3*XL2]), 64'h0F0F_0F0F);
    rst2 = 0;
    tick();
    rst2 = 1;
    sweep_small("s2.mid");
    rs_addr2 = {AW2'(15), AW2'(0), AW2'(15), AW2'(3)};
    #1;
    chk("s2.mid.x3.d", 64'(rs_data2[XL2-1:0]), 64'h0);
    chk("s2.mid.x3.b", 64'(rs_busy2[0]), 64'h0);
    chk("s2.mid.x15.d", 64'(rs_data2[2*XL2-1:XL2]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
